// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the halfword memory bus master.
package mem_bus_pkg;

    localparam int HALF_W = 16;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bus_if.sv
// Core request/response handshake plus the halfword bus, seen from the master
// (mem_bus_master) and from its environment (core + bus responder).
interface mem_bus_if;
    import mem_bus_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_wide;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*HALF_W-1:0]   req_wdata;

    logic                  rsp_valid;
    logic [2*HALF_W-1:0]   rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_W-1:0]     addr;
    logic [HALF_W-1:0]     write;
    logic                  we;
    logic                  re;
    logic [HALF_W-1:0]     read;
    logic                  ready;

    modport master (
        input  req_valid, req_write, req_wide, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output addr, write, we, re,
        input  read, ready
    );

    modport slave (
        output req_valid, req_write, req_wide, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  addr, write, we, re,
        output read, ready
    );

endinterface

// File: rtl/mem_bus_phase_timer.sv
// Per-phase cycle counter: 0 in the first cycle of a phase, saturating; flags read latency reached
// and (with MEM_TIMEOUT_EN) the last allowed cycle of a phase. No backpressure.
module mem_bus_phase_timer #(
    parameter int READ_LATENCY   = 1
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic lat_met
`ifdef MEM_TIMEOUT_EN
    , output logic timeout
`endif
);

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (TO_W > 3) ? TO_W : 3;
`else
    localparam int CNT_W = 3;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(READ_LATENCY);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lat_met = (cnt_q >= LAT);

`ifdef MEM_TIMEOUT_EN
    // Abort decision is taken in the last permitted cycle, so the phase lasts exactly TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign timeout = (cnt_q >= TO_LAST);
`endif

endmodule

// File: rtl/mem_bus_master.sv
// Splits 16/32-bit core loads/stores into LO/HI halfword bus phases; narrow store 2 cycles, narrow load 2+READ_LATENCY.
// Bus ready=0 stalls the phase; one request at a time (req_ready only in IDLE). Optional MEM_TIMEOUT_EN aborts stuck phases.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic       clk,
    input logic       rst,
    mem_bus_if.master bus
);

    if (READ_LATENCY < 0 || READ_LATENCY > 7 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_bus_master: READ_LATENCY must be 0..7 and TIMEOUT_CYCLES >= 1");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2*HALF_W-1:0] wdata_q, wdata_d;
    logic [2*HALF_W-1:0] rdata_q, rdata_d;
    logic                write_q, write_d;
    logic                wide_q, wide_d;
    logic                lat_met;
    logic                phase_done;
    logic                in_phase;
    logic                timer_clr;
`ifdef MEM_TIMEOUT_EN
    logic                timeout;
    logic                err_q, err_d;
`endif

    assign in_phase  = (state_q == LO) || (state_q == HI);
    assign timer_clr = !in_phase || (state_d != state_q);

    mem_bus_phase_timer #(
        .READ_LATENCY   (READ_LATENCY)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .lat_met (lat_met)
`ifdef MEM_TIMEOUT_EN
        , .timeout (timeout)
`endif
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        write_d       = write_q;
        wide_d        = wide_q;
`ifdef MEM_TIMEOUT_EN
        err_d         = err_q;
`endif
        phase_done    = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.addr      = '0;
        bus.write     = '0;
        bus.we        = 1'b0;
        bus.re        = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    wide_d  = bus.req_wide;
                    rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = LO;
                end
            end
            LO, HI: begin
                bus.addr = (state_q == HI) ? addr_q + 32'd1 : addr_q;
                bus.we   = write_q;
                bus.re   = !write_q;
                if (write_q) begin
                    bus.write = (state_q == HI) ? wdata_q[2*HALF_W-1:HALF_W] : wdata_q[HALF_W-1:0];
                end
                // Loads must also wait out the read latency before ready counts.
                phase_done = bus.ready && (write_q || lat_met);
                if (phase_done) begin
                    if (!write_q) begin
                        if (state_q == HI) begin
                            rdata_d[2*HALF_W-1:HALF_W] = bus.read;
                        end else begin
                            rdata_d[HALF_W-1:0] = bus.read;
                        end
                    end
                    state_d = (state_q == LO && wide_q) ? HI : RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            wide_q  <= wide_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: transaction-level model (queue of pending halfword phases) checked every cycle,
// directed cases with literal expectations, then randomized traffic with random ready and occasional reset.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int RL = 1;
`ifdef MEM_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_if bus_if ();

    mem_bus_master #(
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted request becomes a queue of halfword phases followed by one response cycle.
    typedef struct {
        logic [31:0] a;
        logic [15:0] wd;
        bit          rd;
        bit          hi;
    } ph_t;

    ph_t         ph_q[$];
    bit          m_resp     = 1'b0;
    bit          m_err      = 1'b0;
    bit          model_live = 1'b0;
    int          m_cnt      = 0;
    logic [31:0] m_rdata    = '0;

    initial begin
        ph_t         p;
        logic        e_rdy, e_vld, e_we, e_re;
        logic [31:0] e_addr;
        logic [15:0] e_wr;
        forever begin
            @(negedge clk);
            if (model_live) begin
                e_rdy = 1'b0; e_vld = 1'b0; e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wr = '0;
                if (ph_q.size() > 0) begin
                    e_addr = ph_q[0].a;
                    e_we   = !ph_q[0].rd;
                    e_re   = ph_q[0].rd;
                    e_wr   = ph_q[0].rd ? 16'h0 : ph_q[0].wd;
                end else if (m_resp) begin
                    e_vld = 1'b1;
                end else begin
                    e_rdy = 1'b1;
                end
                check("cmp_req_ready", 32'(bus_if.req_ready), 32'(e_rdy));
                check("cmp_rsp_valid", 32'(bus_if.rsp_valid), 32'(e_vld));
                check("cmp_addr",      bus_if.addr,           e_addr);
                check("cmp_we",        32'(bus_if.we),        32'(e_we));
                check("cmp_re",        32'(bus_if.re),        32'(e_re));
                check("cmp_write",     32'(bus_if.write),     32'(e_wr));
                if (e_vld) begin
                    check("cmp_rsp_rdata", bus_if.rsp_rdata,    m_rdata);
                    check("cmp_rsp_err",   32'(bus_if.rsp_err), 32'(m_err));
                end
            end

            if (rst) begin
                ph_q.delete();
                m_resp = 1'b0; m_err = 1'b0; m_rdata = '0; m_cnt = 0;
                model_live = 1'b1;
            end else if (ph_q.size() > 0) begin
                p = ph_q[0];
                if (bus_if.ready && (!p.rd || m_cnt >= RL)) begin
                    if (p.rd) begin
                        if (p.hi) m_rdata[31:16] = bus_if.read;
                        else      m_rdata[15:0]  = bus_if.read;
                    end
                    void'(ph_q.pop_front());
                    m_cnt = 0;
                    if (ph_q.size() == 0) m_resp = 1'b1;
                end else if (TO_EN && m_cnt + 1 >= TO) begin
                    ph_q.delete();
                    m_rdata = '0; m_err = 1'b1; m_resp = 1'b1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_resp) begin
                m_resp = 1'b0;
            end else if (bus_if.req_valid) begin
                p.a  = bus_if.req_addr;
                p.wd = bus_if.req_wdata[15:0];
                p.rd = !bus_if.req_write;
                p.hi = 1'b0;
                ph_q.push_back(p);
                if (bus_if.req_wide) begin
                    p.a  = bus_if.req_addr + 32'd1;
                    p.wd = bus_if.req_wdata[31:16];
                    p.hi = 1'b1;
                    ph_q.push_back(p);
                end
                m_rdata = '0; m_err = 1'b0; m_cnt = 0;
            end
        end
    end

    // Read-data source: 0 random, 1 fixed value, 2 hash of the address the model says is on the bus.
    int          rd_mode  = 0;
    logic [15:0] rd_fixed = 16'h0;

    function automatic logic [15:0] rd_hash(input logic [31:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        case (rd_mode)
            0:       bus_if.read = 16'($urandom);
            1:       bus_if.read = rd_fixed;
            default: bus_if.read = (ph_q.size() > 0) ? rd_hash(ph_q[0].a) : 16'h0;
        endcase
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus_if.req_ready !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check("wait_idle", 32'(bus_if.req_ready), 32'd1);
    endtask

    task automatic issue(input bit w, input bit wide, input logic [31:0] a, input logic [31:0] d);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = w;
        bus_if.req_wide  = wide;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        step();
        bus_if.req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_wide  = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.read      = '0;
        bus_if.ready     = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus_if.rsp_rdata,      32'd0);
        check("rst_rsp_err",   32'(bus_if.rsp_err),   32'd0);
        check("rst_addr",      bus_if.addr,           32'd0);
        check("rst_we_re",     32'({bus_if.we, bus_if.re}), 32'd0);
        check("rst_write",     32'(bus_if.write),     32'd0);

        // Narrow load, minimum latency: rsp_valid three cycles after the handshake.
        rd_mode = 1; rd_fixed = 16'h1234; bus_if.ready = 1'b1;
        wait_idle();
        issue(1'b0, 1'b0, 32'h0000_C800, 32'h0);
        check("nl_t1_re",   32'(bus_if.re), 32'd1);
        check("nl_t1_addr", bus_if.addr,    32'h0000_C800);
        step();
        check("nl_t2_re",   32'(bus_if.re), 32'd1);
        step();
        check("nl_t3_vld",  32'(bus_if.rsp_valid), 32'd1);
        check("nl_t3_data", bus_if.rsp_rdata,      32'h0000_1234);
        check("nl_t3_err",  32'(bus_if.rsp_err),   32'd0);
        step();
        check("nl_t4_vld",  32'(bus_if.rsp_valid), 32'd0);

        // Wide store: LO then HI halfword, response one cycle later.
        wait_idle();
        issue(1'b1, 1'b1, 32'h0000_F000, 32'hDEAD_BEEF);
        check("ws_lo_we",    32'(bus_if.we),    32'd1);
        check("ws_lo_addr",  bus_if.addr,       32'h0000_F000);
        check("ws_lo_write", 32'(bus_if.write), 32'h0000_BEEF);
        step();
        check("ws_hi_addr",  bus_if.addr,       32'h0000_F001);
        check("ws_hi_write", 32'(bus_if.write), 32'h0000_DEAD);
        step();
        check("ws_vld",      32'(bus_if.rsp_valid), 32'd1);
        check("ws_rdata",    bus_if.rsp_rdata,      32'd0);

        // Wide load wrapping the address space.
        rd_mode = 2;
        wait_idle();
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        check("wl_lo_addr", bus_if.addr, 32'hFFFF_FFFF);
        step(); step();
        check("wl_hi_addr", bus_if.addr,    32'h0000_0000);
        check("wl_hi_re",   32'(bus_if.re), 32'd1);
        step(); step();
        check("wl_vld",     32'(bus_if.rsp_valid), 32'd1);
        check("wl_rdata",   bus_if.rsp_rdata,      32'h5A5A_A5A5);

        // Narrow load stalled by ready=0 for five cycles.
        wait_idle();
        bus_if.ready = 1'b0;
        issue(1'b0, 1'b0, 32'h0000_0100, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            check("stall_re",   32'(bus_if.re), 32'd1);
            check("stall_addr", bus_if.addr,    32'h0000_0100);
            step();
        end
        bus_if.ready = 1'b1;
        check("stall_t6_vld", 32'(bus_if.rsp_valid), 32'd0);
        step();
        check("stall_t7_vld",  32'(bus_if.rsp_valid), 32'd1);
        check("stall_t7_data", bus_if.rsp_rdata,      32'h0000_5B5A);

        // Reset during the HI phase of a wide store.
        wait_idle();
        issue(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678);
        step();
        check("rh_hi_addr",  bus_if.addr,       32'h0000_2001);
        check("rh_hi_write", 32'(bus_if.write), 32'h0000_1234);
        rst = 1'b1;
        step();
        check("rh_we_drop",  32'(bus_if.we),        32'd0);
        check("rh_no_vld",   32'(bus_if.rsp_valid), 32'd0);
        rst = 1'b0;
        step();
        check("rh_ready",    32'(bus_if.req_ready), 32'd1);
        check("rh_no_vld2",  32'(bus_if.rsp_valid), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Responder stuck: phase aborted after TO cycles with rsp_err.
        wait_idle();
        bus_if.ready = 1'b0;
        issue(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        for (int k = 1; k <= TO; k++) begin
            check("to_re", 32'(bus_if.re), 32'd1);
            step();
        end
        check("to_vld",   32'(bus_if.rsp_valid), 32'd1);
        check("to_err",   32'(bus_if.rsp_err),   32'd1);
        check("to_rdata", bus_if.rsp_rdata,      32'd0);
        step();
        check("to_idle",  32'(bus_if.req_ready), 32'd1);
        bus_if.ready = 1'b1;
`endif

        // Randomized traffic; the per-cycle compare process carries the checking.
        rd_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 299) == 0);
            bus_if.req_valid = $urandom_range(0, 1) == 1;
            bus_if.req_write = $urandom_range(0, 1) == 1;
            bus_if.req_wide  = $urandom_range(0, 1) == 1;
            bus_if.req_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus_if.req_wdata = $urandom;
            bus_if.ready     = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.ready     = 1'b1;
        wait_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
